// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-requester BRAM port arbiter.
package bram_arb_pkg;

    // Arbiter states. LOCKk parks the port on requester k for a burst.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Requester identity carried alongside read tags (0 or 1).
    typedef logic req_id_t;

    // Width of the optional per-requester grant counters.
    localparam int STATS_WIDTH = 16;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] value);
        logic [STATS_WIDTH-1:0] one;
        one = {{(STATS_WIDTH-1){1'b0}}, 1'b1};
        return (&value) ? value : value + one;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_read_tag_pipe.sv
// Read tag pipeline: a {valid, id} shift register, READ_LATENCY+1 stages deep.
// Stage 0 is loaded on the edge that ends the grant cycle, so stage k is
// visible k+1 cycles after the grant. The stage before last marks the cycle
// in which the BRAM output belongs to that read; the last stage is the return
// strobe. READ_LATENCY must be at least 1.
module read_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_valid,
    input  req_id_t push_id,
    output logic    cap_valid,
    output req_id_t cap_id,
    output logic    ret_valid,
    output req_id_t ret_id
);

    localparam int STAGES = READ_LATENCY + 1;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] id_q;

    // Shift tags toward the return end every cycle; reset drops in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q[0] <= push_valid;
            id_q[0]    <= push_id;
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    assign cap_valid = valid_q[STAGES-2];
    assign cap_id    = id_q[STAGES-2];
    assign ret_valid = valid_q[STAGES-1];
    assign ret_id    = id_q[STAGES-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of a single-port block_memory user port.
// Round-robin with an optional burst lock, registered command issue, and
// tagged routing of read data back to the issuing requester.
//
// Optional build macro BRAM_ARB_STATS_EN adds saturating per-requester grant
// counters (grants0_o/grants1_o) with a synchronous clear (stats_clear_i).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | round-robin between requesters; last_winner loses a tie
// LOCK0 | port held for requester 0; requester 1 is never granted
// LOCK1 | port held for requester 1; requester 0 is never granted
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter int WIDTH        = 33,
    parameter int READ_LATENCY = 2,
    localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_i,
    input  logic                  we0_i,
    input  logic                  lock0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [WIDTH-1:0]      din0_i,

    input  logic                  req1_i,
    input  logic                  we1_i,
    input  logic                  lock1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [WIDTH-1:0]      din1_i,

    output logic                  gnt0_o,
    output logic                  gnt1_o,
    output logic                  rvalid0_o,
    output logic                  rvalid1_o,
    output logic [WIDTH-1:0]      rdata0_o,
    output logic [WIDTH-1:0]      rdata1_o,

    output logic [ADDR_WIDTH-1:0] user_addr_o,
    output logic [WIDTH-1:0]      user_din_o,
    output logic                  user_we_o,
    input  logic [WIDTH-1:0]      user_dout_i
`ifdef BRAM_ARB_STATS_EN
    ,
    input  logic                  stats_clear_i,
    output logic [STATS_WIDTH-1:0] grants0_o,
    output logic [STATS_WIDTH-1:0] grants1_o
`endif
);

    arb_state_t state;
    req_id_t    last_winner;

    logic gnt0;
    logic gnt1;

    logic    cap_valid;
    req_id_t cap_id;
    logic    ret_valid;
    req_id_t ret_id;

    // Grant decode: a lock owner is served exclusively; otherwise round-robin.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            LOCK0: gnt0 = req0_i;
            LOCK1: gnt1 = req1_i;
            default: begin
                if (req0_i && req1_i) begin
                    if (last_winner == 1'b1) begin
                        gnt0 = 1'b1;
                    end else begin
                        gnt1 = 1'b1;
                    end
                end else begin
                    gnt0 = req0_i;
                    gnt1 = req1_i;
                end
            end
        endcase
    end

    assign gnt0_o = gnt0;
    assign gnt1_o = gnt1;

    // Lock state machine and round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_winner <= 1'b1;
        end else begin
            if (gnt0) begin
                last_winner <= 1'b0;
            end else if (gnt1) begin
                last_winner <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (gnt0 && lock0_i) begin
                        state <= LOCK0;
                    end else if (gnt1 && lock1_i) begin
                        state <= LOCK1;
                    end
                end
                // Dropping the request or a final unlocked grant ends the burst.
                LOCK0: begin
                    if (!(gnt0 && lock0_i)) begin
                        state <= IDLE;
                    end
                end
                LOCK1: begin
                    if (!(gnt1 && lock1_i)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue register: the winner's command hits the BRAM on the next cycle;
    // address and data hold when idle so the read port sees a stable address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            user_addr_o <= '0;
            user_din_o  <= '0;
            user_we_o   <= 1'b0;
        end else begin
            user_we_o <= 1'b0;
            if (gnt0) begin
                user_addr_o <= addr0_i;
                user_din_o  <= din0_i;
                user_we_o   <= we0_i;
            end else if (gnt1) begin
                user_addr_o <= addr1_i;
                user_din_o  <= din1_i;
                user_we_o   <= we1_i;
            end
        end
    end

    read_tag_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid ((gnt0 && !we0_i) || (gnt1 && !we1_i)),
        .push_id    (gnt1),
        .cap_valid  (cap_valid),
        .cap_id     (cap_id),
        .ret_valid  (ret_valid),
        .ret_id     (ret_id)
    );

    // Capture BRAM output for the tagged owner; the other requester's data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_o <= '0;
            rdata1_o <= '0;
        end else if (cap_valid) begin
            if (cap_id == 1'b0) begin
                rdata0_o <= user_dout_i;
            end else begin
                rdata1_o <= user_dout_i;
            end
        end
    end

    assign rvalid0_o = ret_valid && (ret_id == 1'b0);
    assign rvalid1_o = ret_valid && (ret_id == 1'b1);

`ifdef BRAM_ARB_STATS_EN
    // Saturating grant counters; clear wins over a same-cycle grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grants0_o <= '0;
            grants1_o <= '0;
        end else if (stats_clear_i) begin
            grants0_o <= '0;
            grants1_o <= '0;
        end else begin
            if (gnt0) begin
                grants0_o <= sat_inc(grants0_o);
            end
            if (gnt1) begin
                grants1_o <= sat_inc(grants1_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural single-port BRAM.
// BRAM model: writes land on the edge ending the issue cycle; the read
// output register loads mem[user_addr] on the same edge.
module tb_bram_port_arbiter;
    import bram_arb_pkg::*;

    localparam int DEPTH = 256;
    localparam int WIDTH = 33;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 0, we0 = 0, lock0 = 0;
    logic [AW-1:0]    addr0 = '0;
    logic [WIDTH-1:0] din0 = '0;
    logic             req1 = 0, we1 = 0, lock1 = 0;
    logic [AW-1:0]    addr1 = '0;
    logic [WIDTH-1:0] din1 = '0;
    logic             gnt0, gnt1, rvalid0, rvalid1;
    logic [WIDTH-1:0] rdata0, rdata1;
    logic [AW-1:0]    user_addr;
    logic [WIDTH-1:0] user_din;
    logic             user_we;
    logic [WIDTH-1:0] user_dout = '0;
`ifdef BRAM_ARB_STATS_EN
    logic             stats_clear = 1'b0;
    logic [15:0]      grants0, grants1;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic             pre_en = 1'b0;
    logic [AW-1:0]    pre_addr = '0;
    logic [WIDTH-1:0] pre_data = '0;

    int passed = 0;
    int total  = 0;

    bram_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_i      (req0),
        .we0_i       (we0),
        .lock0_i     (lock0),
        .addr0_i     (addr0),
        .din0_i      (din0),
        .req1_i      (req1),
        .we1_i       (we1),
        .lock1_i     (lock1),
        .addr1_i     (addr1),
        .din1_i      (din1),
        .gnt0_o      (gnt0),
        .gnt1_o      (gnt1),
        .rvalid0_o   (rvalid0),
        .rvalid1_o   (rvalid1),
        .rdata0_o    (rdata0),
        .rdata1_o    (rdata1),
        .user_addr_o (user_addr),
        .user_din_o  (user_din),
        .user_we_o   (user_we),
        .user_dout_i (user_dout)
`ifdef BRAM_ARB_STATS_EN
        ,
        .stats_clear_i (stats_clear),
        .grants0_o     (grants0),
        .grants1_o     (grants1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (user_we) begin
            mem[user_addr] <= user_din;
        end
        user_dout <= mem[user_addr];
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive0(input logic r, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req0 = r; we0 = w; lock0 = l; addr0 = a; din0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req1 = r; we1 = w; lock1 = l; addr1 = a; din1 = d;
    endtask

    task automatic idle;
        drive0(0, 0, 0, '0, '0);
        drive1(0, 0, 0, '0, '0);
    endtask

    // Hold reset for three edges, preloading mem[0]=0xA and mem[1]=0xB.
    task automatic do_reset;
        rst = 1'b1;
        idle();
        pre_en = 1'b1; pre_addr = 8'd0; pre_data = 33'hA;
        cyc();
        pre_addr = 8'd1; pre_data = 33'hB;
        cyc();
        pre_en = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        do_reset();

        // Reset state
        #1;
        check("rst_we", user_we, 0);
        check("rst_addr", user_addr, 0);
        check("rst_din", user_din, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_state", dut.state, IDLE);
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);

        // Requester 0: write 0x1_2345_6789 to addr 5, then read it back
        drive0(1, 1, 0, 8'd5, 33'h1_2345_6789);
        #1;
        check("wr_gnt0", gnt0, 1);
        check("wr_gnt1", gnt1, 0);
        cyc();
        drive0(1, 0, 0, 8'd5, '0);
        #1;
        check("rd_gnt0", gnt0, 1);
        check("wr_issue_we", user_we, 1);
        check("wr_issue_addr", user_addr, 5);
        check("wr_issue_din", user_din, 33'h1_2345_6789);
        cyc();
        idle();
        #1;
        check("rd_issue_we", user_we, 0);
        check("rd_issue_addr", user_addr, 5);
        cyc();
        #1;
        check("rd_early_rvalid0", rvalid0, 0);
        cyc();
        #1;
        check("rd_rvalid0", rvalid0, 1);
        check("rd_rdata0", rdata0, 33'h1_2345_6789);
        check("rd_rvalid1", rvalid1, 0);
        cyc();
        #1;
        check("rd_strobe_end", rvalid0, 0);
        check("rd_rdata0_hold", rdata0, 33'h1_2345_6789);

        // Both requesters read continuously from reset: round-robin 0,1,0,1
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                drive0(1, 0, 0, 8'd0, '0);
                drive1(1, 0, 0, 8'd1, '0);
            end else begin
                idle();
            end
            #1;
            if (i < 4) begin
                check("rr_gnt0", gnt0, (i % 2) == 0);
                check("rr_gnt1", gnt1, (i % 2) == 1);
            end
            if (i >= 3 && i < 7) begin
                check("rr_rvalid0", rvalid0, ((i - 3) % 2) == 0);
                check("rr_rvalid1", rvalid1, ((i - 3) % 2) == 1);
                if (((i - 3) % 2) == 0) check("rr_rdata0", rdata0, 33'hA);
                else                     check("rr_rdata1", rdata1, 33'hB);
            end
            if (i == 7) begin
                check("rr_quiet0", rvalid0, 0);
                check("rr_quiet1", rvalid1, 0);
            end
            cyc();
        end

        // Lock burst: requester 0 writes 10..13, lock dropped on the 4th
        for (int k = 0; k < 8; k++) begin
            if (k < 4)       drive0(1, 1, k != 3, 8'(10 + k), 33'(256 + k));
            else if (k == 4) drive0(1, 1, 0, 8'd20, 33'h55);
            else             drive0(0, 0, 0, '0, '0);
            if (k <= 4) drive1(1, 0, 0, 8'd1, '0);
            else        drive1(0, 0, 0, '0, '0);
            #1;
            if (k < 4) begin
                check("lk_gnt0", gnt0, 1);
                check("lk_gnt1", gnt1, 0);
            end
            if (k == 4) begin
                check("lk_release_gnt1", gnt1, 1);
                check("lk_release_gnt0", gnt0, 0);
                check("lk_release_state", dut.state, IDLE);
            end
            if (k >= 1 && k <= 4) begin
                check("lk_addr", user_addr, 10 + k - 1);
                check("lk_we", user_we, 1);
                check("lk_din", user_din, 256 + k - 1);
            end
            if (k >= 1 && k <= 3) check("lk_state", dut.state, LOCK0);
            if (k == 7) begin
                check("lk_rvalid1", rvalid1, 1);
                check("lk_rdata1", rdata1, 33'hB);
            end
            cyc();
        end

        // Read-after-write: requester 1 writes 0x7 to addr 3, requester 0 reads it
        idle();
        drive1(1, 1, 0, 8'd3, 33'h7);
        #1;
        check("raw_gnt1", gnt1, 1);
        cyc();
        idle();
        drive0(1, 0, 0, 8'd3, '0);
        #1;
        check("raw_gnt0", gnt0, 1);
        check("raw_wr_we", user_we, 1);
        check("raw_wr_addr", user_addr, 3);
        cyc();
        idle();
        cyc();
        cyc();
        #1;
        check("raw_rvalid0", rvalid0, 1);
        check("raw_rdata0", rdata0, 33'h7);
        check("raw_rvalid1", rvalid1, 0);
        cyc();

        // Reset with two locked reads in flight
        drive0(1, 0, 1, 8'd0, '0);
        #1;
        check("mid_gnt0_a", gnt0, 1);
        cyc();
        drive0(1, 0, 1, 8'd1, '0);
        #1;
        check("mid_state_lock", dut.state, LOCK0);
        check("mid_gnt0_b", gnt0, 1);
        cyc();
        idle();
        #1;
        rst = 1'b1;
        #1;
        check("mid_rvalid0", rvalid0, 0);
        check("mid_we", user_we, 0);
        check("mid_state", dut.state, IDLE);
        check("mid_addr", user_addr, 0);
        cyc();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("post_rvalid0", rvalid0, 0);
            check("post_rvalid1", rvalid1, 0);
            check("post_we", user_we, 0);
            cyc();
        end

`ifdef BRAM_ARB_STATS_EN
        check("st_rst0", grants0, 0);
        drive0(1, 1, 0, 8'd40, 33'h1);
        for (int n = 0; n < 70000; n++) cyc();
        #1;
        check("st_sat0", grants0, 16'hFFFF);
        check("st_idle1", grants1, 0);
        stats_clear = 1'b1;
        cyc();
        stats_clear = 1'b0;
        idle();
        #1;
        check("st_clear0", grants0, 0);
        cyc();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
